elbeth_dmem_responder: RTL and testbench
========================================

ELBETH_DMEM_RESPONDER -- requirements
Module: elbeth_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dmem_en  input  1  request valid; core holds it high until dmem_ready.
REQ-006 SHALL have port dmem_wr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port dmem_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port dmem_sign  input  1  1 = sign-extend load data, 0 = zero-extend.
REQ-009 SHALL have port dmem_addr  input  32  byte address.
REQ-010 SHALL have port dmem_wdata  input  32  store data, right-justified (unshifted).
REQ-011 SHALL have port dmem_rdata  output  32  load data, right-justified, extended per dmem_sign.
REQ-012 SHALL have port dmem_ready  output  1  one-cycle response strobe.
REQ-013 SHALL have port dmem_error  output  1  access fault, valid only while dmem_ready=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; dmem_ready and dmem_error registered, dmem_ready = (state==RESP).
REQ-015 In IDLE with dmem_en=1 at a rising edge, SHALL latch addr, wdata, wr, size, sign and a fault flag.
REQ-016 Fault flag SHALL be set for: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-017 Faulted request SHALL go IDLE->RESP directly (ready one cycle after acceptance edge), dmem_error=1, dmem_rdata=0, no array access.
REQ-018 Non-faulted request SHALL go to WAIT with counter=WAIT_CYCLES, or straight to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, counter SHALL decrement each cycle; at the edge where counter==1 (or entry with 0) transition to RESP.
REQ-020 Total latency SHALL be: dmem_ready high in the cycle WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 Array write SHALL occur only on the edge entering RESP, writing only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all).
REQ-022 Load data SHALL be captured on the edge entering RESP: selected lane(s) shifted to bit 0, bits above size filled with MSB if dmem_sign=1 else 0.
REQ-023 Store responses SHALL drive dmem_rdata=0 and dmem_error=0.
REQ-024 dmem_rdata SHALL hold its value until the next entry into RESP.
REQ-025 RESP SHALL last exactly one cycle, then IDLE; dmem_en high during RESP SHALL NOT start a new request (same request being acknowledged).
REQ-026 A new request SHALL be accepted no earlier than the first IDLE cycle after RESP (back-to-back issue gap = 1 cycle).
REQ-027 If dmem_en falls during WAIT (core flush), SHALL abort to IDLE at next edge, no write committed, no dmem_ready.
REQ-028 Inputs other than dmem_en SHALL be ignored outside the IDLE acceptance edge.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, counter 0, dmem_ready=0, dmem_error=0, dmem_rdata=0.
REQ-030 Reset asserted before the RESP-entry edge SHALL discard the pending request with no array write.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 First request SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-033 WAIT_CYCLES=2: word store 0xDEADBEEF @0x100, then word load @0x100 -> ready 3 cycles after each acceptance, rdata=0xDEADBEEF, error=0.
REQ-034 Byte store 0x80 @0x101, signed byte load @0x101 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x100 -> 0xDEAD80EF.
REQ-035 Halfword load @0x103 and word load @0x102 -> ready one cycle after acceptance, error=1, rdata=0; memory unchanged.
REQ-036 Store @0x200, dmem_en dropped in WAIT -> no ready, later load @0x200 returns prior contents; same with rst pulsed low mid-WAIT -> outputs 0 immediately.
REQ-037 WAIT_CYCLES=0, three back-to-back loads with dmem_en held high -> ready every 2 cycles, each request acknowledged exactly once.
REQ-038 Address with addr[31:2]=DEPTH_WORDS -> error=1, no wrap-around write to word 0.

Source files
------------

// File: rtl/elbeth_dmem_responder_if.sv
// Data-memory request/response bus between a core (master) and the responder (slave).
interface elbeth_dmem_responder_if;
  logic        dmem_en;
  logic        dmem_wr;
  logic [1:0]  dmem_size;
  logic        dmem_sign;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_error;

  modport master (
    output dmem_en, dmem_wr, dmem_size, dmem_sign, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready, dmem_error
  );

  modport slave (
    input  dmem_en, dmem_wr, dmem_size, dmem_sign, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready, dmem_error
  );
endinterface

// File: rtl/elbeth_dmem_responder.sv
// Word-organised data memory with byte/half/word access, fixed wait states and a
// one-cycle registered response strobe.
module elbeth_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                       clk,
  input logic                       rst,
  elbeth_dmem_responder_if.slave    bus
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          fault_q;
  logic          ready_q;
  logic          error_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          in_idle;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_wr;
  logic [1:0]    req_size;
  logic          req_sign;
  logic          req_fault;
  logic          addr_fault;
  logic [IdxW-1:0] req_idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;
  logic          access;
  logic          mem_we;

  // In IDLE the request is taken straight from the bus so a zero-wait access can
  // complete on its acceptance edge; afterwards the latched copy is used.
  assign in_idle   = (state_q == StIdle);
  assign req_addr  = in_idle ? bus.dmem_addr  : addr_q;
  assign req_wdata = in_idle ? bus.dmem_wdata : wdata_q;
  assign req_wr    = in_idle ? bus.dmem_wr    : wr_q;
  assign req_size  = in_idle ? bus.dmem_size  : size_q;
  assign req_sign  = in_idle ? bus.dmem_sign  : sign_q;
  assign req_idx   = req_addr[IdxW+1:2];

  assign addr_fault = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);

  always_comb begin
    req_fault = 1'b0;
    if (in_idle) begin
      unique case (req_size)
        2'b00:   req_fault = addr_fault;
        2'b01:   req_fault = addr_fault | req_addr[0];
        2'b10:   req_fault = addr_fault | (|req_addr[1:0]);
        default: req_fault = 1'b1;
      endcase
    end else begin
      req_fault = fault_q;
    end
  end

  always_comb begin
    be    = 4'b1111;
    wlane = req_wdata;
    unique case (req_size)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
    endcase
  end

  assign rd_word  = mem[req_idx];
  assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_word;
    unique case (req_size)
      2'b00:   load_data = {{24{req_sign & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = {{16{req_sign & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Non-faulted access completing on this edge: the only point the array is touched.
  always_comb begin
    access = 1'b0;
    unique case (state_q)
      StIdle:  access = bus.dmem_en && !req_fault && (WAIT_CYCLES == 0);
      StWait:  access = bus.dmem_en && !req_fault && (cnt_q == 4'd1);
      default: access = 1'b0;
    endcase
  end

  assign mem_we = access && req_wr && rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[req_idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.dmem_en) begin
            addr_q  <= bus.dmem_addr;
            wdata_q <= bus.dmem_wdata;
            wr_q    <= bus.dmem_wr;
            size_q  <= bus.dmem_size;
            sign_q  <= bus.dmem_sign;
            fault_q <= req_fault;
            if (req_fault) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              error_q <= 1'b1;
              rdata_q <= 32'd0;
            end else if (access) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              rdata_q <= req_wr ? 32'd0 : load_data;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (!bus.dmem_en) begin
            // Core flushed the request: drop it without committing anything.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (access) begin
            state_q <= StResp;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            rdata_q <= req_wr ? 32'd0 : load_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dmem_ready = ready_q;
  assign bus.dmem_error = error_q;
  assign bus.dmem_rdata = rdata_q;

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_elbeth_dmem_responder;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rd;
  int          lat;
  logic        er;
  logic        seen;
  logic [31:0] addr0 [3];
  logic [31:0] data0 [3];

  elbeth_dmem_responder_if bus2 ();
  elbeth_dmem_responder_if bus0 ();

  elbeth_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  elbeth_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the two-wait-state DUT; lat counts cycles from acceptance edge.
  task automatic access2(input logic wr, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata_o, output int lat_o, output logic err_o);
    @(negedge clk);
    bus2.dmem_en    = 1'b1;
    bus2.dmem_wr    = wr;
    bus2.dmem_size  = size;
    bus2.dmem_sign  = sign;
    bus2.dmem_addr  = addr;
    bus2.dmem_wdata = wdata;
    @(posedge clk);
    lat_o   = 0;
    rdata_o = 32'hxxxx_xxxx;
    err_o   = 1'bx;
    for (int n = 1; n <= 8; n++) begin
      #1;
      if (bus2.dmem_ready) begin
        lat_o   = n;
        rdata_o = bus2.dmem_rdata;
        err_o   = bus2.dmem_error;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus2.dmem_en    = 1'b0;
    bus2.dmem_wr    = 1'b1;
    bus2.dmem_addr  = 32'h0000_0100;
    bus2.dmem_wdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    addr0[0] = 32'h10; addr0[1] = 32'h14; addr0[2] = 32'h18;
    data0[0] = 32'h0A0B_0C0D; data0[1] = 32'h1122_3344; data0[2] = 32'h8899_AABB;
    bus2.dmem_en = 1'b0; bus2.dmem_wr = 1'b0; bus2.dmem_size = 2'b10; bus2.dmem_sign = 1'b0;
    bus2.dmem_addr = 32'd0; bus2.dmem_wdata = 32'd0;
    bus0.dmem_en = 1'b0; bus0.dmem_wr = 1'b0; bus0.dmem_size = 2'b10; bus0.dmem_sign = 1'b0;
    bus0.dmem_addr = 32'd0; bus0.dmem_wdata = 32'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    check("rst_ready", {31'd0, bus2.dmem_ready}, 32'd0);
    check("rst_error", {31'd0, bus2.dmem_error}, 32'd0);
    check("rst_rdata", bus2.dmem_rdata, 32'd0);
    check("rst_ready0", {31'd0, bus0.dmem_ready}, 32'd0);

    // Release reset just after an edge so the request lands on the first rising edge.
    @(posedge clk);
    #2 rst = 1'b1;

    access2(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, lat, er);
    check("st_word_lat", 32'(lat), 32'd3);
    check("st_word_err", {31'd0, er}, 32'd0);
    check("st_word_rdata", rd, 32'd0);
    access2(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, rd, lat, er);
    check("ld_word_lat", 32'(lat), 32'd3);
    check("ld_word_rdata", rd, 32'hDEAD_BEEF);
    check("ld_word_err", {31'd0, er}, 32'd0);

    access2(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_5680, rd, lat, er);
    check("st_byte_lat", 32'(lat), 32'd3);
    access2(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, rd, lat, er);
    check("ld_byte_s", rd, 32'hFFFF_FF80);
    access2(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, rd, lat, er);
    check("ld_byte_u", rd, 32'h0000_0080);
    access2(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, rd, lat, er);
    check("ld_word_merge", rd, 32'hDEAD_80EF);
    access2(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, rd, lat, er);
    check("ld_half_s", rd, 32'hFFFF_DEAD);
    access2(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF_1234, rd, lat, er);
    access2(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, rd, lat, er);
    check("ld_half_u", rd, 32'h0000_1234);

    // Misaligned and illegal-size accesses fault on the next cycle.
    access2(1'b0, 2'b01, 1'b0, 32'h103, 32'd0, rd, lat, er);
    check("mis_half_lat", 32'(lat), 32'd1);
    check("mis_half_err", {31'd0, er}, 32'd1);
    access2(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, rd, lat, er);
    check("mis_word_lat", 32'(lat), 32'd1);
    check("mis_word_err", {31'd0, er}, 32'd1);
    check("mis_word_rdata", rd, 32'd0);
    access2(1'b1, 2'b10, 1'b0, 32'h102, 32'h0000_0000, rd, lat, er);
    check("mis_st_err", {31'd0, er}, 32'd1);
    access2(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, rd, lat, er);
    check("ill_size_err", {31'd0, er}, 32'd1);
    access2(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, rd, lat, er);
    check("mis_unchanged", rd, 32'h1234_80EF);

    // Flush during WAIT: no response, no write.
    access2(1'b1, 2'b10, 1'b0, 32'h200, 32'h1111_2222, rd, lat, er);
    @(negedge clk);
    bus2.dmem_en = 1'b1; bus2.dmem_wr = 1'b1; bus2.dmem_size = 2'b10;
    bus2.dmem_addr = 32'h200; bus2.dmem_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus2.dmem_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 seen = seen | bus2.dmem_ready;
    end
    check("flush_no_ready", {31'd0, seen}, 32'd0);
    access2(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, rd, lat, er);
    check("flush_no_write", rd, 32'h1111_2222);

    // Reset pulse during WAIT: outputs clear at once, pending store discarded.
    @(negedge clk);
    bus2.dmem_en = 1'b1; bus2.dmem_wr = 1'b1; bus2.dmem_size = 2'b10;
    bus2.dmem_addr = 32'h200; bus2.dmem_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rdata", bus2.dmem_rdata, 32'd0);
    check("mid_rst_ready", {31'd0, bus2.dmem_ready}, 32'd0);
    check("mid_rst_error", {31'd0, bus2.dmem_error}, 32'd0);
    bus2.dmem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access2(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, rd, lat, er);
    check("rst_no_write", rd, 32'h1111_2222);

    // One word past the end must fault and must not alias onto word 0.
    access2(1'b1, 2'b10, 1'b0, 32'h0, 32'h55AA_55AA, rd, lat, er);
    access2(1'b1, 2'b10, 1'b0, 32'h1000, 32'h9999_9999, rd, lat, er);
    check("oob_lat", 32'(lat), 32'd1);
    check("oob_err", {31'd0, er}, 32'd1);
    access2(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, rd, lat, er);
    check("oob_no_wrap", rd, 32'h55AA_55AA);

    // Zero-wait DUT with dmem_en held high: one response every two cycles.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      bus0.dmem_en = 1'b1; bus0.dmem_wr = (p == 0); bus0.dmem_size = 2'b10;
      bus0.dmem_sign = 1'b0; bus0.dmem_addr = addr0[0]; bus0.dmem_wdata = data0[0];
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("b2b_ready_p%0d_k%0d", p, k), {31'd0, bus0.dmem_ready}, 32'd1);
        check($sformatf("b2b_rdata_p%0d_k%0d", p, k), bus0.dmem_rdata,
              (p == 0) ? 32'd0 : data0[k]);
        check($sformatf("b2b_err_p%0d_k%0d", p, k), {31'd0, bus0.dmem_error}, 32'd0);
        @(negedge clk);
        if (k < 2) begin
          bus0.dmem_addr  = addr0[k+1];
          bus0.dmem_wdata = data0[k+1];
        end else begin
          bus0.dmem_en = 1'b0;
        end
        @(posedge clk);
        #1;
        check($sformatf("b2b_gap_p%0d_k%0d", p, k), {31'd0, bus0.dmem_ready}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
